// File: rtl/combo_lock_if.sv
// combo_lock_if: button pulses in, lock status out, between debouncer front-end and lock FSM.
interface combo_lock_if #(
   parameter int NUM_BTN = 4,
   parameter int DCW     = 3,
   parameter int FW      = 2
);
   logic [NUM_BTN-1:0] btn_pulse;
   logic               unlocked;
   logic               alarm;
   logic [DCW-1:0]     digit_cnt;
   logic [FW-1:0]      fail_cnt;
   logic [2:0]         state;
   modport master (output btn_pulse, input unlocked, alarm, digit_cnt, fail_cnt, state);
   modport slave  (input btn_pulse, output unlocked, alarm, digit_cnt, fail_cnt, state);
endinterface

// File: rtl/combo_lock_fsm.sv
// combo_lock_fsm: combination lock with failed-attempt lockout and inactivity timeout.
// Define COMBO_PROGRAM_EN to let digits entered while open reprogram the stored code.
module combo_lock_fsm #(
   parameter int                             NUM_BTN      = 4,
   parameter int                             DIGIT_W      = $clog2(NUM_BTN),
   parameter int                             CODE_LEN     = 4,
   parameter logic [CODE_LEN*DIGIT_W-1:0]    DEFAULT_CODE = 8'h1B,
   parameter int                             MAX_FAIL     = 3,
   parameter int                             TIMEOUT_CYC  = 1_000_000_000,
   parameter int                             LOCKOUT_CYC  = 500_000_000
) (
   input logic         clk_i,
   input logic         rst_ni,
   combo_lock_if.slave bus
);
   localparam int CW   = CODE_LEN*DIGIT_W;
   localparam int DCW  = $clog2(CODE_LEN+1);
   localparam int FW   = $clog2(MAX_FAIL+1);
   localparam int MAXC = TIMEOUT_CYC > LOCKOUT_CYC ? TIMEOUT_CYC : LOCKOUT_CYC;
   localparam int TW   = $clog2(MAXC);

   typedef enum logic [2:0] {IDLE = 3'd0, ENTRY = 3'd1, CHECK = 3'd2, OPEN = 3'd3, LOCKOUT = 3'd4} state_t;

   state_t         state_q, state_d;
   logic [CW-1:0]  entry_q, entry_d, code;
   logic [DCW-1:0] cnt_q, cnt_d;
   logic [FW-1:0]  fail_q, fail_d;
   logic [TW-1:0]  timer_q, timer_d;
   logic           unlocked_q, alarm_q;
   logic           press;
   logic [DIGIT_W-1:0] digit;
   logic [CW-1:0]  shifted;
   logic           to_hit, lo_hit;

`ifdef COMBO_PROGRAM_EN
   logic [CW-1:0] code_q, code_d;
   assign code = code_q;
`else
   assign code = DEFAULT_CODE;
`endif

   // only a strictly one-hot pulse vector is a press
   assign press   = (bus.btn_pulse != '0) && ((bus.btn_pulse & (bus.btn_pulse - NUM_BTN'(1))) == '0);
   assign shifted = (entry_q << DIGIT_W) | CW'(digit);
   assign to_hit  = timer_q == TW'(TIMEOUT_CYC-1);
   assign lo_hit  = timer_q == TW'(LOCKOUT_CYC-1);

   always_comb begin
      digit = '0;
      for (int i = 0; i < NUM_BTN; i++)
         if (bus.btn_pulse[i]) digit = DIGIT_W'(i);
   end

   always_comb begin
      state_d = state_q;
      entry_d = entry_q;
      cnt_d   = cnt_q;
      fail_d  = fail_q;
      timer_d = timer_q + TW'(1);
`ifdef COMBO_PROGRAM_EN
      code_d  = code_q;
`endif
      case (state_q)
         IDLE, ENTRY: begin
            if (press) begin
               entry_d = shifted;
               cnt_d   = cnt_q + DCW'(1);
               timer_d = '0;
               state_d = cnt_d == DCW'(CODE_LEN) ? CHECK : ENTRY;
            end else if (state_q == IDLE || to_hit) begin
               state_d = IDLE;
               entry_d = '0;
               cnt_d   = '0;
               timer_d = '0;
            end
         end
         CHECK: begin
            entry_d = '0;
            cnt_d   = '0;
            timer_d = '0;
            if (entry_q == code) begin
               state_d = OPEN;
               fail_d  = '0;
            end else begin
               fail_d  = fail_q == FW'(MAX_FAIL) ? fail_q : fail_q + FW'(1);
               state_d = fail_d == FW'(MAX_FAIL) ? LOCKOUT : IDLE;
            end
         end
         OPEN: begin
`ifdef COMBO_PROGRAM_EN
            if (press) begin
               entry_d = shifted;
               cnt_d   = cnt_q + DCW'(1);
               timer_d = '0;
               if (cnt_d == DCW'(CODE_LEN)) begin
                  code_d  = shifted;
                  entry_d = '0;
                  cnt_d   = '0;
                  state_d = IDLE;
               end
            end else if (to_hit) begin
               entry_d = '0;
               cnt_d   = '0;
               timer_d = '0;
               state_d = IDLE;
            end
`else
            if (press || to_hit) begin
               timer_d = '0;
               state_d = IDLE;
            end
`endif
         end
         LOCKOUT: begin
            if (lo_hit) begin
               timer_d = '0;
               fail_d  = '0;
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
            entry_d = '0;
            cnt_d   = '0;
            timer_d = '0;
         end
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state_q    <= IDLE;
         entry_q    <= '0;
         cnt_q      <= '0;
         fail_q     <= '0;
         timer_q    <= '0;
         unlocked_q <= 1'b0;
         alarm_q    <= 1'b0;
`ifdef COMBO_PROGRAM_EN
         code_q     <= DEFAULT_CODE;
`endif
      end else begin
         state_q    <= state_d;
         entry_q    <= entry_d;
         cnt_q      <= cnt_d;
         fail_q     <= fail_d;
         timer_q    <= timer_d;
         unlocked_q <= state_d == OPEN;
         alarm_q    <= state_d == LOCKOUT;
`ifdef COMBO_PROGRAM_EN
         code_q     <= code_d;
`endif
      end
   end

   assign bus.unlocked  = unlocked_q;
   assign bus.alarm     = alarm_q;
   assign bus.digit_cnt = cnt_q;
   assign bus.fail_cnt  = fail_q;
   assign bus.state     = state_q;
endmodule

// File: tb/tb_combo_lock_fsm.sv
// tb_combo_lock_fsm: directed scenarios for the lock FSM with short timeout/lockout periods.
module tb_combo_lock_fsm;
   logic clk = 1'b0;
   logic rst_n;
   int   n_tests = 0;
   int   n_fail  = 0;

   combo_lock_if bus ();

   combo_lock_fsm #(.TIMEOUT_CYC(20), .LOCKOUT_CYC(50)) dut (
      .clk_i (clk),
      .rst_ni(rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   initial begin
      #1ms;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   task automatic press(input logic [3:0] v);
      bus.btn_pulse = v;
      @(negedge clk);
      bus.btn_pulse = 4'b0000;
   endtask

   task automatic enter4(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c, input logic [3:0] d);
      press(a); press(b); press(c); press(d);
   endtask

   task automatic test_reset;
      rst_n = 1'b0;
      bus.btn_pulse = 4'b0000;
      repeat (2) @(negedge clk);
      n_tests++; if (bus.state !== 3'd0) begin n_fail++; $display("FAIL reset_state: got %0d expected 0", bus.state); end
      n_tests++; if (bus.unlocked !== 1'b0 || bus.alarm !== 1'b0) begin n_fail++; $display("FAIL reset_flags: got unl=%b alarm=%b expected 0 0", bus.unlocked, bus.alarm); end
      n_tests++; if (bus.digit_cnt !== 3'd0 || bus.fail_cnt !== 2'd0) begin n_fail++; $display("FAIL reset_counts: got dig=%0d fail=%0d expected 0 0", bus.digit_cnt, bus.fail_cnt); end
      rst_n = 1'b1;
   endtask

   task automatic test_unlock;
      press(4'b0001); press(4'b0010); press(4'b0100);
      n_tests++; if (bus.state !== 3'd1 || bus.digit_cnt !== 3'd3) begin n_fail++; $display("FAIL unlock_entry: got st=%0d dig=%0d expected 1 3", bus.state, bus.digit_cnt); end
      press(4'b1000);
      n_tests++; if (bus.state !== 3'd2 || bus.unlocked !== 1'b0) begin n_fail++; $display("FAIL unlock_check: got st=%0d unl=%b expected 2 0", bus.state, bus.unlocked); end
      @(negedge clk);
      n_tests++; if (bus.state !== 3'd3 || bus.unlocked !== 1'b1) begin n_fail++; $display("FAIL unlock_open: got st=%0d unl=%b expected 3 1", bus.state, bus.unlocked); end
      n_tests++; if (bus.fail_cnt !== 2'd0 || bus.digit_cnt !== 3'd0) begin n_fail++; $display("FAIL unlock_counts: got fail=%0d dig=%0d expected 0 0", bus.fail_cnt, bus.digit_cnt); end
      press(4'b0010);
`ifdef COMBO_PROGRAM_EN
      n_tests++; if (bus.state !== 3'd3 || bus.digit_cnt !== 3'd1) begin n_fail++; $display("FAIL unlock_prog_digit: got st=%0d dig=%0d expected 3 1", bus.state, bus.digit_cnt); end
      repeat (20) @(negedge clk);
`endif
      n_tests++; if (bus.state !== 3'd0 || bus.unlocked !== 1'b0) begin n_fail++; $display("FAIL unlock_relock: got st=%0d unl=%b expected 0 0", bus.state, bus.unlocked); end
   endtask

   task automatic test_lockout;
      int n_alarm;
      enter4(4'b0001, 4'b0001, 4'b0001, 4'b0001);
      @(negedge clk);
      n_tests++; if (bus.state !== 3'd0 || bus.fail_cnt !== 2'd1) begin n_fail++; $display("FAIL lockout_fail1: got st=%0d fail=%0d expected 0 1", bus.state, bus.fail_cnt); end
      enter4(4'b0001, 4'b0001, 4'b0001, 4'b0001);
      @(negedge clk);
      n_tests++; if (bus.state !== 3'd0 || bus.fail_cnt !== 2'd2) begin n_fail++; $display("FAIL lockout_fail2: got st=%0d fail=%0d expected 0 2", bus.state, bus.fail_cnt); end
      enter4(4'b0001, 4'b0001, 4'b0001, 4'b0001);
      @(negedge clk);
      n_tests++; if (bus.state !== 3'd4 || bus.alarm !== 1'b1 || bus.fail_cnt !== 2'd3) begin n_fail++; $display("FAIL lockout_enter: got st=%0d alarm=%b fail=%0d expected 4 1 3", bus.state, bus.alarm, bus.fail_cnt); end
      n_alarm = 1;
      for (int i = 0; i < 60; i++) begin
         bus.btn_pulse = i < 40 ? 4'b0001 << (i % 4) : 4'b0000;
         @(negedge clk);
         if (bus.alarm) n_alarm++;
      end
      bus.btn_pulse = 4'b0000;
      n_tests++; if (n_alarm !== 50) begin n_fail++; $display("FAIL lockout_len: got %0d cycles expected 50", n_alarm); end
      n_tests++; if (bus.state !== 3'd0 || bus.alarm !== 1'b0) begin n_fail++; $display("FAIL lockout_exit: got st=%0d alarm=%b expected 0 0", bus.state, bus.alarm); end
      n_tests++; if (bus.fail_cnt !== 2'd0 || bus.digit_cnt !== 3'd0) begin n_fail++; $display("FAIL lockout_counts: got fail=%0d dig=%0d expected 0 0", bus.fail_cnt, bus.digit_cnt); end
   endtask

   task automatic test_timeout;
      enter4(4'b0001, 4'b0001, 4'b0001, 4'b0001);
      @(negedge clk);
      press(4'b0001); press(4'b0010);
      n_tests++; if (bus.state !== 3'd1 || bus.digit_cnt !== 3'd2) begin n_fail++; $display("FAIL timeout_entry: got st=%0d dig=%0d expected 1 2", bus.state, bus.digit_cnt); end
      press(4'b0011);
      n_tests++; if (bus.digit_cnt !== 3'd2) begin n_fail++; $display("FAIL timeout_multibit: got dig=%0d expected 2", bus.digit_cnt); end
      repeat (18) @(negedge clk);
      n_tests++; if (bus.state !== 3'd1) begin n_fail++; $display("FAIL timeout_early: got st=%0d expected 1", bus.state); end
      @(negedge clk);
      n_tests++; if (bus.state !== 3'd0 || bus.digit_cnt !== 3'd0) begin n_fail++; $display("FAIL timeout_idle: got st=%0d dig=%0d expected 0 0", bus.state, bus.digit_cnt); end
      n_tests++; if (bus.fail_cnt !== 2'd1) begin n_fail++; $display("FAIL timeout_fail: got %0d expected 1", bus.fail_cnt); end
   endtask

   task automatic test_back_to_back;
      enter4(4'b0001, 4'b0010, 4'b0100, 4'b1000);
      press(4'b0001);
      n_tests++; if (bus.state !== 3'd3 || bus.unlocked !== 1'b1 || bus.digit_cnt !== 3'd0) begin n_fail++; $display("FAIL b2b_check_drop: got st=%0d unl=%b dig=%0d expected 3 1 0", bus.state, bus.unlocked, bus.digit_cnt); end
      n_tests++; if (bus.fail_cnt !== 2'd0) begin n_fail++; $display("FAIL b2b_fail_clear: got %0d expected 0", bus.fail_cnt); end
      repeat (19) @(negedge clk);
      n_tests++; if (bus.state !== 3'd3) begin n_fail++; $display("FAIL b2b_open_early: got st=%0d expected 3", bus.state); end
      @(negedge clk);
      n_tests++; if (bus.state !== 3'd0 || bus.unlocked !== 1'b0) begin n_fail++; $display("FAIL b2b_open_timeout: got st=%0d unl=%b expected 0 0", bus.state, bus.unlocked); end
      press(4'b1111);
      n_tests++; if (bus.state !== 3'd0 || bus.digit_cnt !== 3'd0) begin n_fail++; $display("FAIL b2b_idle_multibit: got st=%0d dig=%0d expected 0 0", bus.state, bus.digit_cnt); end
   endtask

   task automatic test_reset_in_open;
      enter4(4'b0001, 4'b0010, 4'b0100, 4'b1000);
      repeat (2) @(negedge clk);
      n_tests++; if (bus.unlocked !== 1'b1) begin n_fail++; $display("FAIL rstopen_pre: got unl=%b expected 1", bus.unlocked); end
      rst_n = 1'b0;
      @(negedge clk);
      n_tests++; if (bus.unlocked !== 1'b0 || bus.state !== 3'd0) begin n_fail++; $display("FAIL rstopen_reset: got unl=%b st=%0d expected 0 0", bus.unlocked, bus.state); end
      rst_n = 1'b1;
      enter4(4'b0001, 4'b0010, 4'b0100, 4'b1000);
      @(negedge clk);
      n_tests++; if (bus.unlocked !== 1'b1) begin n_fail++; $display("FAIL rstopen_reopen: got unl=%b expected 1", bus.unlocked); end
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

`ifdef COMBO_PROGRAM_EN
   task automatic test_program;
      enter4(4'b0001, 4'b0010, 4'b0100, 4'b1000);
      @(negedge clk);
      press(4'b1000);
      n_tests++; if (bus.state !== 3'd3 || bus.unlocked !== 1'b1 || bus.digit_cnt !== 3'd1) begin n_fail++; $display("FAIL prog_first: got st=%0d unl=%b dig=%0d expected 3 1 1", bus.state, bus.unlocked, bus.digit_cnt); end
      press(4'b1000); press(4'b1000); press(4'b1000);
      n_tests++; if (bus.state !== 3'd0 || bus.unlocked !== 1'b0) begin n_fail++; $display("FAIL prog_done: got st=%0d unl=%b expected 0 0", bus.state, bus.unlocked); end
      enter4(4'b0001, 4'b0010, 4'b0100, 4'b1000);
      @(negedge clk);
      n_tests++; if (bus.state !== 3'd0 || bus.fail_cnt !== 2'd1) begin n_fail++; $display("FAIL prog_old_code: got st=%0d fail=%0d expected 0 1", bus.state, bus.fail_cnt); end
      enter4(4'b1000, 4'b1000, 4'b1000, 4'b1000);
      @(negedge clk);
      n_tests++; if (bus.unlocked !== 1'b1 || bus.fail_cnt !== 2'd0) begin n_fail++; $display("FAIL prog_new_code: got unl=%b fail=%0d expected 1 0", bus.unlocked, bus.fail_cnt); end
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      enter4(4'b0001, 4'b0010, 4'b0100, 4'b1000);
      @(negedge clk);
      n_tests++; if (bus.unlocked !== 1'b1) begin n_fail++; $display("FAIL prog_reset_code: got unl=%b expected 1", bus.unlocked); end
   endtask
`endif

   initial begin
      test_reset;
      test_unlock;
      test_lockout;
      test_timeout;
      test_back_to_back;
      test_reset_in_open;
`ifdef COMBO_PROGRAM_EN
      test_program;
`endif
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
